// File: rtl/alu_issue_sched_if.sv
// Bus bundle between the reservation stations / CDB and the ALU issue scheduler.
// Handshake semantics: the scheduler's grant to FU f is a one-cycle combinational pulse
// (grant_valid[f] with grant_idx slice f). The requester must drop req_valid[i] on the
// cycle after entry i is granted; an ungranted request simply stays asserted. A finished
// result is offered on fu_result_valid[f] / fu_tag slice f and held until cdb_ready[f]
// is seen high on a clock edge. squash flushes everything on the next edge.
// The master modport is the RS/CDB side; the slave modport is the scheduler.
interface alu_issue_sched_if #(
  parameter int NUM_REQ = 8,
  parameter int NUM_FU  = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic                    squash;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_is_mul;
  logic [NUM_FU-1:0]       cdb_ready;
  logic [NUM_FU-1:0]       grant_valid;
  logic [NUM_FU*IDX_W-1:0] grant_idx;
  logic [NUM_FU-1:0]       fu_busy;
  logic [NUM_FU-1:0]       fu_result_valid;
  logic [NUM_FU*IDX_W-1:0] fu_tag;
  // Debug visibility of the per-FU state machines and the round-robin pointer.
  logic [NUM_FU*2-1:0]     fu_state_dbg;
  logic [IDX_W-1:0]        rr_ptr_dbg;

  modport master (
    output squash, req_valid, req_is_mul, cdb_ready,
    input  grant_valid, grant_idx, fu_busy, fu_result_valid, fu_tag,
    input  fu_state_dbg, rr_ptr_dbg
  );

  modport slave (
    input  squash, req_valid, req_is_mul, cdb_ready,
    output grant_valid, grant_idx, fu_busy, fu_result_valid, fu_tag,
    output fu_state_dbg, rr_ptr_dbg
  );
endinterface

// File: rtl/alu_issue_sched.sv
// ALU issue scheduler: shares NUM_FU ALU functional units among NUM_REQ reservation-station
// entries. Free FUs are filled each cycle, in ascending FU order, with ready entries picked
// round-robin starting at rr_ptr. Each FU runs a small IDLE/EXEC/DONE machine: simple ops
// finish the cycle after issue, multiplies occupy the FU for MUL_LAT cycles, and finished
// results are held in DONE until the CDB accepts them.
module alu_issue_sched #(
  parameter int NUM_REQ = 8,
  parameter int NUM_FU  = 2,
  parameter int MUL_LAT = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  alu_issue_sched_if.slave   bus
);

  // Counter only needs to hold MUL_LAT-2 (the EXEC cycles beyond the first).
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_EXEC = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  fu_state_e          state_q [NUM_FU];
  logic [CNT_W-1:0]   cnt_q   [NUM_FU];
  logic [IDX_W-1:0]   tag_q   [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr_q;

  logic [NUM_FU-1:0]  fu_free;
  logic [NUM_REQ-1:0] blocked;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_FU-1:0]  gv;
  logic [IDX_W-1:0]   gi [NUM_FU];
  logic               found;
  logic               any_grant;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   rr_next;

  // An FU can take a new op when idle, or when its held result leaves on the CDB this cycle.
  always_comb begin
    fu_free = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      fu_free[f] = (state_q[f] == FU_IDLE) ||
                   ((state_q[f] == FU_DONE) && bus.cdb_ready[f]);
    end
  end

  // Entries still owned by an occupied FU must not be issued a second time.
  always_comb begin
    blocked = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (state_q[f] != FU_IDLE) blocked[tag_q[f]] = 1'b1;
    end
  end

  // Round-robin pick: each free FU takes the next eligible entry scanning from rr_ptr.
  always_comb begin
    cand      = bus.req_valid & ~blocked;
    gv        = '0;
    found     = 1'b0;
    any_grant = 1'b0;
    scan_idx  = '0;
    last_idx  = rr_ptr_q;
    for (int f = 0; f < NUM_FU; f++) gi[f] = '0;
    if (!reset && !bus.squash) begin
      for (int f = 0; f < NUM_FU; f++) begin
        found = 1'b0;
        if (fu_free[f]) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr_q + IDX_W'(k);
            if (!found && cand[scan_idx]) begin
              found          = 1'b1;
              gv[f]          = 1'b1;
              gi[f]          = scan_idx;
              cand[scan_idx] = 1'b0;
              last_idx       = scan_idx;
              any_grant      = 1'b1;
            end
          end
        end
      end
    end
    rr_next = any_grant ? (last_idx + IDX_W'(1)) : rr_ptr_q;
  end

  // Per-FU state machines, tags, latency counters and the round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        state_q[f] <= FU_IDLE;
        cnt_q[f]   <= '0;
        tag_q[f]   <= '0;
      end
    end else if (bus.squash) begin
      // Flush drops every in-flight or held result; tags are left as-is.
      rr_ptr_q <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        state_q[f] <= FU_IDLE;
        cnt_q[f]   <= '0;
      end
    end else begin
      rr_ptr_q <= rr_next;
      for (int f = 0; f < NUM_FU; f++) begin
        case (state_q[f])
          FU_IDLE: begin
            if (gv[f]) begin
              tag_q[f] <= gi[f];
              if (bus.req_is_mul[gi[f]]) begin
                state_q[f] <= FU_EXEC;
                cnt_q[f]   <= CNT_INIT;
              end else begin
                state_q[f] <= FU_DONE;
              end
            end
          end
          FU_EXEC: begin
            if (cnt_q[f] != '0) cnt_q[f] <= cnt_q[f] - CNT_W'(1);
            else                state_q[f] <= FU_DONE;
          end
          FU_DONE: begin
            if (bus.cdb_ready[f]) begin
              if (gv[f]) begin
                tag_q[f] <= gi[f];
                if (bus.req_is_mul[gi[f]]) begin
                  state_q[f] <= FU_EXEC;
                  cnt_q[f]   <= CNT_INIT;
                end else begin
                  state_q[f] <= FU_DONE;
                end
              end else begin
                state_q[f] <= FU_IDLE;
              end
            end
          end
          default: state_q[f] <= FU_IDLE;
        endcase
      end
    end
  end

  assign bus.grant_valid = gv;
  assign bus.rr_ptr_dbg  = rr_ptr_q;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu_out
    assign bus.grant_idx[f*IDX_W +: IDX_W] = gi[f];
    assign bus.fu_tag[f*IDX_W +: IDX_W]    = tag_q[f];
    assign bus.fu_busy[f]                  = (state_q[f] != FU_IDLE);
    assign bus.fu_result_valid[f]          = (state_q[f] == FU_DONE);
    assign bus.fu_state_dbg[f*2 +: 2]      = state_q[f];
  end

endmodule
